// File: rtl/cv32e40p_mult_ft_scrub_ctrl_pkg.sv
// Shared types and helpers for the TMR multiplier fault-management controller.
package cv32e40p_mult_ft_scrub_ctrl_pkg;

  localparam int unsigned FT_NUM_REPLICAS = 3;
  localparam int unsigned FT_CNT_W        = 4;

  typedef enum logic [1:0] {
    FT_IDLE   = 2'd0,
    FT_DRAIN  = 2'd1,
    FT_SCRUB  = 2'd2,
    FT_SETTLE = 2'd3
  } ft_scrub_state_e;

  // Number of replicas flagged in one voter sample.
  function automatic logic [1:0] ft_popcount3(input logic [2:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
  endfunction

endpackage

// File: rtl/cv32e40p_mult_ft_scrub_ctrl_err_counter.sv
// Per-replica fault bookkeeping: saturating disagreement counter, scrub
// counter (2-bit, saturating) and the permanent mask bit.
// sat_nxt reflects the counter value after this cycle's increment/decay but
// before any scrub clear, so the controller can react without waiting a cycle.
module cv32e40p_ft_err_counter
  import cv32e40p_mult_ft_scrub_ctrl_pkg::*;
#(
  parameter int unsigned ERR_THRESH = 4,
  parameter int unsigned MAX_SCRUBS = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc,
  input  logic       scrub,
  input  logic       decay,
  input  logic       mask_set,
  input  logic       clear,
  output logic       sat_nxt,
  output logic [1:0] scrub_cnt,
  output logic       mask
);

  localparam logic [FT_CNT_W-1:0] THRESH = FT_CNT_W'(ERR_THRESH);

  logic [FT_CNT_W-1:0] cnt_r;
  logic [FT_CNT_W-1:0] cnt_pre_s;
  logic [1:0]          scrub_cnt_r;
  logic                mask_r;

  // Next counter value from increment/decay; increment wins over decay.
  always_comb begin
    cnt_pre_s = cnt_r;
    if (inc) begin
      if (cnt_r < THRESH) begin
        cnt_pre_s = cnt_r + 4'd1;
      end else begin
        cnt_pre_s = cnt_r;
      end
    end else if (decay && (cnt_r != 4'd0)) begin
      cnt_pre_s = cnt_r - 4'd1;
    end else begin
      cnt_pre_s = cnt_r;
    end
  end

  assign sat_nxt   = (cnt_pre_s == THRESH);
  assign scrub_cnt = scrub_cnt_r;
  assign mask      = mask_r;

  // Disagreement counter; a scrub starts the replica from a clean count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= 4'd0;
    end else if (scrub) begin
      cnt_r <= 4'd0;
    end else begin
      cnt_r <= cnt_pre_s;
    end
  end

  // Scrub history, saturating at 3.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scrub_cnt_r <= 2'd0;
    end else if (clear) begin
      scrub_cnt_r <= scrub ? 2'd1 : 2'd0;
    end else if (scrub && (scrub_cnt_r != 2'd3)) begin
      scrub_cnt_r <= scrub_cnt_r + 2'd1;
    end
  end

  // Permanent-failure mask; a new failure wins over a coincident clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_r <= 1'b0;
    end else if (mask_set) begin
      mask_r <= 1'b1;
    end else if (clear) begin
      mask_r <= 1'b0;
    end
  end

endmodule

// File: rtl/cv32e40p_mult_ft_scrub_ctrl.sv
// Fault-management controller for the triplicated multiplier: counts voter
// disagreements per replica, drains and scrubs a replica at threshold, and
// masks replicas that keep failing. Optional leaky counters are enabled with
// the CV32E40P_MULT_FT_LEAKY_EN macro.
module cv32e40p_mult_ft_scrub_ctrl
  import cv32e40p_mult_ft_scrub_ctrl_pkg::*;
#(
  parameter int unsigned ERR_THRESH   = 4,
  parameter int unsigned RST_CYCLES   = 2,
  parameter int unsigned MAX_SCRUBS   = 3
`ifdef CV32E40P_MULT_FT_LEAKY_EN
  ,
  parameter int unsigned DECAY_PERIOD = 256
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       err_valid_i,
  input  logic [2:0] err_i,
  input  logic       mult_idle_i,
  input  logic       clear_i,
  output logic       stall_o,
  output logic [2:0] replica_rst_no,
  output logic [2:0] replica_mask_o,
  output logic       scrub_done_o,
  output logic       uncorrectable_o
);

  localparam logic [3:0] RST_LAST = 4'(RST_CYCLES - 1);
  localparam logic [1:0] MAXS     = 2'(MAX_SCRUBS);

  ft_scrub_state_e state_r, next_state_s;
  logic [1:0] sel_r, sel_nxt_s, trig_idx_s, pop_s;
  logic [3:0] rst_cnt_r;
  logic       trig_s, scrub_entry_s, clear_s, decay_s;
  logic [2:0] inc_s, busy_s, scrub_s, mask_set_s, sat_nxt_s, mask_s;
  logic [2:0][1:0] scrub_cnt_s;
  logic       stall_r, stall_nxt_s, done_r, done_nxt_s, uncorr_r;
  logic [2:0] replica_rst_n_r, rst_nxt_s;

`ifdef CV32E40P_MULT_FT_LEAKY_EN
  localparam int unsigned DECAY_W = $clog2(DECAY_PERIOD);
  logic [DECAY_W-1:0] decay_cnt_r;

  // Free-running decay timer; the all-ones value marks a wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      decay_cnt_r <= '0;
    end else begin
      decay_cnt_r <= decay_cnt_r + 1'b1;
    end
  end

  assign decay_s = &decay_cnt_r;
`else
  assign decay_s = 1'b0;
`endif

  // Qualify single-replica disagreements; the replica under scrub is ignored.
  always_comb begin
    pop_s = ft_popcount3(err_i);
    for (int k = 0; k < FT_NUM_REPLICAS; k++) begin
      busy_s[k] = ((state_r == FT_SCRUB) || (state_r == FT_SETTLE)) && (sel_r == 2'(k));
      inc_s[k]  = err_valid_i && (pop_s == 2'd1) && err_i[k] && !mask_s[k] && !busy_s[k];
    end
  end

  // In IDLE pick the lowest saturated replica to scrub, or mask it if spent.
  always_comb begin
    trig_s     = 1'b0;
    trig_idx_s = 2'd0;
    mask_set_s = 3'b000;
    for (int k = FT_NUM_REPLICAS - 1; k >= 0; k--) begin
      if ((state_r == FT_IDLE) && sat_nxt_s[k] && !mask_s[k]) begin
        if (scrub_cnt_s[k] >= MAXS) begin
          mask_set_s[k] = 1'b1;
        end else begin
          trig_s     = 1'b1;
          trig_idx_s = 2'(k);
        end
      end else begin
        mask_set_s[k] = 1'b0;
      end
    end
  end

  // Next-state logic; an already idle multiplier skips DRAIN entirely.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      FT_IDLE: begin
        if (trig_s) begin
          next_state_s = mult_idle_i ? FT_SCRUB : FT_DRAIN;
        end else begin
          next_state_s = FT_IDLE;
        end
      end
      FT_DRAIN: begin
        if (mult_idle_i) begin
          next_state_s = FT_SCRUB;
        end else begin
          next_state_s = FT_DRAIN;
        end
      end
      FT_SCRUB: begin
        if (rst_cnt_r == RST_LAST) begin
          next_state_s = FT_SETTLE;
        end else begin
          next_state_s = FT_SCRUB;
        end
      end
      FT_SETTLE: next_state_s = FT_IDLE;
      default:   next_state_s = FT_IDLE;
    endcase
  end

  // Selected replica is latched when leaving IDLE.
  always_comb begin
    if (state_r == FT_IDLE) begin
      sel_nxt_s = trig_idx_s;
    end else begin
      sel_nxt_s = sel_r;
    end
    scrub_entry_s = (next_state_s == FT_SCRUB) && (state_r != FT_SCRUB);
    clear_s       = clear_i && (state_r == FT_IDLE);
    for (int k = 0; k < FT_NUM_REPLICAS; k++) begin
      scrub_s[k] = scrub_entry_s && (sel_nxt_s == 2'(k));
    end
  end

  // Output decode from the next state so outputs come straight from flops.
  always_comb begin
    stall_nxt_s = 1'b0;
    rst_nxt_s   = 3'b111;
    done_nxt_s  = 1'b0;
    case (next_state_s)
      FT_IDLE:  done_nxt_s = (state_r == FT_SETTLE);
      FT_DRAIN: stall_nxt_s = 1'b1;
      FT_SCRUB: begin
        stall_nxt_s = 1'b1;
        for (int k = 0; k < FT_NUM_REPLICAS; k++) begin
          if (sel_nxt_s == 2'(k)) begin
            rst_nxt_s[k] = 1'b0;
          end else begin
            rst_nxt_s[k] = 1'b1;
          end
        end
      end
      FT_SETTLE: stall_nxt_s = 1'b1;
      default:   stall_nxt_s = 1'b0;
    endcase
  end

  // State, selection and reset-hold timer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= FT_IDLE;
      sel_r     <= 2'd0;
      rst_cnt_r <= 4'd0;
    end else begin
      state_r <= next_state_s;
      sel_r   <= sel_nxt_s;
      if (scrub_entry_s) begin
        rst_cnt_r <= 4'd0;
      end else if (state_r == FT_SCRUB) begin
        rst_cnt_r <= rst_cnt_r + 4'd1;
      end
    end
  end

  // Registered outputs; a double disagreement wins over a coincident clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_r         <= 1'b0;
      replica_rst_n_r <= 3'b111;
      done_r          <= 1'b0;
      uncorr_r        <= 1'b0;
    end else begin
      stall_r         <= stall_nxt_s;
      replica_rst_n_r <= rst_nxt_s;
      done_r          <= done_nxt_s;
      if (err_valid_i && (pop_s >= 2'd2)) begin
        uncorr_r <= 1'b1;
      end else if (clear_s) begin
        uncorr_r <= 1'b0;
      end
    end
  end

  for (genvar g = 0; g < FT_NUM_REPLICAS; g++) begin : g_rep
    cv32e40p_ft_err_counter #(
      .ERR_THRESH(ERR_THRESH),
      .MAX_SCRUBS(MAX_SCRUBS)
    ) u_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .inc      (inc_s[g]),
      .scrub    (scrub_s[g]),
      .decay    (decay_s),
      .mask_set (mask_set_s[g]),
      .clear    (clear_s),
      .sat_nxt  (sat_nxt_s[g]),
      .scrub_cnt(scrub_cnt_s[g]),
      .mask     (mask_s[g])
    );
  end

  assign stall_o         = stall_r;
  assign replica_rst_no  = replica_rst_n_r;
  assign replica_mask_o  = mask_s;
  assign scrub_done_o    = done_r;
  assign uncorrectable_o = uncorr_r;

endmodule

// File: tb/tb_cv32e40p_mult_ft_scrub_ctrl.sv
// Directed self-checking bench for cv32e40p_mult_ft_scrub_ctrl.
module tb_cv32e40p_mult_ft_scrub_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       err_valid_i;
  logic [2:0] err_i;
  logic       mult_idle_i;
  logic       clear_i;
  logic       stall_o;
  logic [2:0] replica_rst_no;
  logic [2:0] replica_mask_o;
  logic       scrub_done_o;
  logic       uncorrectable_o;

  int checks = 0;
  int errors = 0;

  cv32e40p_mult_ft_scrub_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .err_valid_i    (err_valid_i),
    .err_i          (err_i),
    .mult_idle_i    (mult_idle_i),
    .clear_i        (clear_i),
    .stall_o        (stall_o),
    .replica_rst_no (replica_rst_no),
    .replica_mask_o (replica_mask_o),
    .scrub_done_o   (scrub_done_o),
    .uncorrectable_o(uncorrectable_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [2:0] e);
    err_valid_i = 1'b1;
    err_i = e;
    step();
    err_valid_i = 1'b0;
    err_i = 3'b000;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; err_valid_i = 1'b0; err_i = 3'b000; mult_idle_i = 1'b1; clear_i = 1'b0;
    #12;
    checks++;
    if ({stall_o, replica_rst_no, replica_mask_o, scrub_done_o, uncorrectable_o} !== 9'b0_111_000_0_0) begin
      errors++;
      $display("FAIL reset_values act=%b exp=%b", {stall_o, replica_rst_no, replica_mask_o, scrub_done_o, uncorrectable_o}, 9'b0_111_000_0_0);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_scrub_basic();
    repeat (3) strobe(3'b001);
    checks++;
    if (stall_o !== 1'b0) begin errors++; $display("FAIL basic_below_thresh stall act=%b exp=0", stall_o); end
    strobe(3'b001);
    checks++;
    if ({stall_o, replica_rst_no} !== 4'b1_110) begin errors++; $display("FAIL basic_scrub1 act=%b exp=1110", {stall_o, replica_rst_no}); end
    step();
    checks++;
    if ({stall_o, replica_rst_no} !== 4'b1_110) begin errors++; $display("FAIL basic_scrub2 act=%b exp=1110", {stall_o, replica_rst_no}); end
    step();
    checks++;
    if ({stall_o, replica_rst_no, scrub_done_o} !== 5'b1_111_0) begin errors++; $display("FAIL basic_settle act=%b exp=11110", {stall_o, replica_rst_no, scrub_done_o}); end
    step();
    checks++;
    if ({stall_o, scrub_done_o} !== 2'b01) begin errors++; $display("FAIL basic_done act=%b exp=01", {stall_o, scrub_done_o}); end
    step();
    checks++;
    if (scrub_done_o !== 1'b0) begin errors++; $display("FAIL basic_done_pulse act=%b exp=0", scrub_done_o); end
  endtask

  task automatic test_drain();
    mult_idle_i = 1'b0;
    repeat (3) strobe(3'b001);
    checks++;
    if (stall_o !== 1'b0) begin errors++; $display("FAIL drain_cnt_cleared stall act=%b exp=0", stall_o); end
    strobe(3'b001);
    checks++;
    if ({stall_o, replica_rst_no} !== 4'b1_111) begin errors++; $display("FAIL drain_entry act=%b exp=1111", {stall_o, replica_rst_no}); end
    repeat (4) begin
      step();
      checks++;
      if ({stall_o, replica_rst_no} !== 4'b1_111) begin errors++; $display("FAIL drain_hold act=%b exp=1111", {stall_o, replica_rst_no}); end
    end
    mult_idle_i = 1'b1;
    step();
    checks++;
    if ({stall_o, replica_rst_no} !== 4'b1_110) begin errors++; $display("FAIL drain_to_scrub act=%b exp=1110", {stall_o, replica_rst_no}); end
    repeat (3) step();
    checks++;
    if (scrub_done_o !== 1'b1) begin errors++; $display("FAIL drain_done act=%b exp=1", scrub_done_o); end
  endtask

  task automatic test_uncorrectable();
    repeat (3) strobe(3'b001);
    strobe(3'b011);
    checks++;
    if ({uncorrectable_o, stall_o} !== 2'b10) begin errors++; $display("FAIL unc_set act=%b exp=10", {uncorrectable_o, stall_o}); end
    step();
    checks++;
    if (stall_o !== 1'b0) begin errors++; $display("FAIL unc_no_count stall act=%b exp=0", stall_o); end
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
    checks++;
    if (uncorrectable_o !== 1'b0) begin errors++; $display("FAIL unc_clear act=%b exp=0", uncorrectable_o); end
    strobe(3'b001);
    checks++;
    if ({stall_o, replica_rst_no} !== 4'b1_110) begin errors++; $display("FAIL unc_cnt_kept act=%b exp=1110", {stall_o, replica_rst_no}); end
    repeat (3) step();
    clear_i = 1'b1;
    strobe(3'b101);
    clear_i = 1'b0;
    checks++;
    if (uncorrectable_o !== 1'b1) begin errors++; $display("FAIL unc_set_wins act=%b exp=1", uncorrectable_o); end
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
    checks++;
    if (uncorrectable_o !== 1'b0) begin errors++; $display("FAIL unc_clear2 act=%b exp=0", uncorrectable_o); end
  endtask

  task automatic test_back_to_back();
    mult_idle_i = 1'b0;
    repeat (4) strobe(3'b010);
    checks++;
    if ({stall_o, replica_rst_no} !== 4'b1_111) begin errors++; $display("FAIL b2b_drain act=%b exp=1111", {stall_o, replica_rst_no}); end
    repeat (4) strobe(3'b001);
    repeat (4) strobe(3'b100);
    mult_idle_i = 1'b1;
    step();
    checks++;
    if (replica_rst_no !== 3'b101) begin errors++; $display("FAIL b2b_scrub1 act=%b exp=101", replica_rst_no); end
    repeat (3) step();
    checks++;
    if ({stall_o, scrub_done_o} !== 2'b01) begin errors++; $display("FAIL b2b_done1 act=%b exp=01", {stall_o, scrub_done_o}); end
    step();
    checks++;
    if ({stall_o, replica_rst_no} !== 4'b1_110) begin errors++; $display("FAIL b2b_scrub0 act=%b exp=1110", {stall_o, replica_rst_no}); end
    repeat (3) step();
    checks++;
    if (scrub_done_o !== 1'b1) begin errors++; $display("FAIL b2b_done0 act=%b exp=1", scrub_done_o); end
    step();
    checks++;
    if ({stall_o, replica_rst_no} !== 4'b1_011) begin errors++; $display("FAIL b2b_scrub2 act=%b exp=1011", {stall_o, replica_rst_no}); end
    repeat (3) step();
    checks++;
    if (scrub_done_o !== 1'b1) begin errors++; $display("FAIL b2b_done2 act=%b exp=1", scrub_done_o); end
  endtask

  task automatic test_mask();
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
    repeat (3) begin
      repeat (4) strobe(3'b010);
      checks++;
      if ({stall_o, replica_rst_no} !== 4'b1_101) begin errors++; $display("FAIL mask_scrub act=%b exp=1101", {stall_o, replica_rst_no}); end
      repeat (3) step();
      checks++;
      if (scrub_done_o !== 1'b1) begin errors++; $display("FAIL mask_scrub_done act=%b exp=1", scrub_done_o); end
    end
    repeat (4) strobe(3'b010);
    checks++;
    if ({replica_mask_o, stall_o, replica_rst_no} !== 7'b010_0_111) begin errors++; $display("FAIL mask_set act=%b exp=0100111", {replica_mask_o, stall_o, replica_rst_no}); end
    repeat (4) strobe(3'b010);
    step();
    checks++;
    if ({stall_o, replica_rst_no} !== 4'b0_111) begin errors++; $display("FAIL mask_ignored act=%b exp=0111", {stall_o, replica_rst_no}); end
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
    checks++;
    if ({replica_mask_o, stall_o} !== 4'b000_0) begin errors++; $display("FAIL mask_clear act=%b exp=0000", {replica_mask_o, stall_o}); end
    step();
    checks++;
    if ({stall_o, replica_rst_no} !== 4'b1_101) begin errors++; $display("FAIL mask_unmasked_scrub act=%b exp=1101", {stall_o, replica_rst_no}); end
    repeat (3) step();
  endtask

  task automatic test_async_reset();
    repeat (4) strobe(3'b100);
    checks++;
    if ({stall_o, replica_rst_no} !== 4'b1_011) begin errors++; $display("FAIL arst_in_scrub act=%b exp=1011", {stall_o, replica_rst_no}); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({stall_o, replica_rst_no, replica_mask_o, scrub_done_o, uncorrectable_o} !== 9'b0_111_000_0_0) begin
      errors++;
      $display("FAIL arst_values act=%b exp=011100000", {stall_o, replica_rst_no, replica_mask_o, scrub_done_o, uncorrectable_o});
    end
    #4;
    rst_n = 1'b1;
    repeat (3) strobe(3'b100);
    checks++;
    if ({stall_o, replica_rst_no} !== 4'b0_111) begin errors++; $display("FAIL arst_cnt_cleared act=%b exp=0111", {stall_o, replica_rst_no}); end
  endtask

`ifdef CV32E40P_MULT_FT_LEAKY_EN
  task automatic test_leaky();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    step();
    repeat (3) strobe(3'b001);
    repeat (256) step();
    strobe(3'b001);
    checks++;
    if (stall_o !== 1'b0) begin errors++; $display("FAIL leaky_decayed act=%b exp=0", stall_o); end
    strobe(3'b001);
    checks++;
    if (stall_o !== 1'b1) begin errors++; $display("FAIL leaky_retrigger act=%b exp=1", stall_o); end
    repeat (4) step();
  endtask
`endif

  initial begin
    test_reset();
    test_scrub_basic();
    test_drain();
    test_uncorrectable();
    test_back_to_back();
    test_mask();
    test_async_reset();
`ifdef CV32E40P_MULT_FT_LEAKY_EN
    test_leaky();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
